// File: rtl/fadd_issue_queue.sv
// Issue queue and result buffer wrapped around a free-running, non-stallable LAT-cycle half-precision adder.
// Optional sticky status accumulator enabled by defining FADD_STICKY_STATUS_EN.
module fadd_issue_queue #(
  parameter int LAT    = 5,
  parameter int QDEPTH = 4,
  parameter int RDEPTH = 8,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  input  logic             req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [15:0]      fa_a,
  output logic [15:0]      fa_b,
  output logic             fa_add_sub,
  input  logic [15:0]      fa_out,
  input  logic [2:0]       fa_status,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic [2:0]       rsp_status,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
`ifdef FADD_STICKY_STATUS_EN
  ,
  input  logic             sticky_clr,
  output logic [2:0]       sticky_status
`endif
);
  localparam int QPW = $clog2(QDEPTH);
  localparam int QCW = $clog2(QDEPTH + 1);
  localparam int RPW = $clog2(RDEPTH);
  localparam int RCW = $clog2(RDEPTH + 1);
  localparam int ICW = $clog2(LAT + 1);
  localparam int SW  = $clog2(LAT + RDEPTH + 1);

  logic [15:0]      qa_mem [QDEPTH];
  logic [15:0]      qb_mem [QDEPTH];
  logic             qop_mem [QDEPTH];
  logic [TAG_W-1:0] qtag_mem [QDEPTH];
  logic [15:0]      rd_mem [RDEPTH];
  logic [2:0]       rs_mem [RDEPTH];
  logic [TAG_W-1:0] rt_mem [RDEPTH];

  logic [QPW-1:0]   q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [QCW-1:0]   q_cnt_q, q_cnt_d;
  logic [RPW-1:0]   r_wr_q, r_wr_d, r_rd_q, r_rd_d;
  logic [RCW-1:0]   r_cnt_q, r_cnt_d;
  logic [ICW-1:0]   inflight_q, inflight_d;
  logic [LAT-1:0]   tp_vld_q, tp_vld_d;
  logic [TAG_W-1:0] tp_tag_q [LAT];
  logic [TAG_W-1:0] tp_tag_d [LAT];

  logic          q_empty, q_full, r_empty;
  logic          push, issue, capture, pop;
  logic [SW-1:0] credit_used;

  // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    q_empty     = (q_cnt_q == '0);
    q_full      = (q_cnt_q == QCW'(QDEPTH));
    r_empty     = (r_cnt_q == '0);
    req_ready   = !rst && !q_full;
    push        = req_valid && req_ready;
    // Credits count in-flight ops as already occupying a result slot.
    credit_used = SW'(inflight_q) + SW'(r_cnt_q);
    issue       = !q_empty && (credit_used < SW'(RDEPTH));
    capture     = tp_vld_q[LAT-1];
    rsp_valid   = !rst && !r_empty;
    pop         = rsp_valid && rsp_ready;

    q_wr_d     = push ? q_wr_q + QPW'(1) : q_wr_q;
    q_rd_d     = issue ? q_rd_q + QPW'(1) : q_rd_q;
    q_cnt_d    = q_cnt_q + QCW'(push) - QCW'(issue);
    r_wr_d     = capture ? r_wr_q + RPW'(1) : r_wr_q;
    r_rd_d     = pop ? r_rd_q + RPW'(1) : r_rd_q;
    r_cnt_d    = r_cnt_q + RCW'(capture) - RCW'(pop);
    inflight_d = inflight_q + ICW'(issue) - ICW'(capture);

    tp_vld_d    = {tp_vld_q[LAT-2:0], issue};
    tp_tag_d[0] = issue ? qtag_mem[q_rd_q] : '0;
    for (int i = 1; i < LAT; i++) tp_tag_d[i] = tp_tag_q[i-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr_q     <= '0;
      q_rd_q     <= '0;
      q_cnt_q    <= '0;
      r_wr_q     <= '0;
      r_rd_q     <= '0;
      r_cnt_q    <= '0;
      inflight_q <= '0;
      tp_vld_q   <= '0;
    end else begin
      q_wr_q     <= q_wr_d;
      q_rd_q     <= q_rd_d;
      q_cnt_q    <= q_cnt_d;
      r_wr_q     <= r_wr_d;
      r_rd_q     <= r_rd_d;
      r_cnt_q    <= r_cnt_d;
      inflight_q <= inflight_d;
      tp_vld_q   <= tp_vld_d;
    end
  end

  // NOTE: storage arrays are not reset; the counts and valid bits above gate every read of them.
  always_ff @(posedge clk) begin
    if (push) begin
      qa_mem[q_wr_q]   <= req_a;
      qb_mem[q_wr_q]   <= req_b;
      qop_mem[q_wr_q]  <= req_op;
      qtag_mem[q_wr_q] <= req_tag;
    end
    if (capture) begin
      rd_mem[r_wr_q] <= fa_out;
      rs_mem[r_wr_q] <= fa_status;
      rt_mem[r_wr_q] <= tp_tag_q[LAT-1];
    end
    tp_tag_q <= tp_tag_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && capture) assert (r_cnt_q != RCW'(RDEPTH));
  end

  always_comb begin
    fa_a       = q_empty ? '0 : qa_mem[q_rd_q];
    fa_b       = q_empty ? '0 : qb_mem[q_rd_q];
    fa_add_sub = q_empty ? 1'b0 : qop_mem[q_rd_q];
    rsp_data   = rsp_valid ? rd_mem[r_rd_q] : '0;
    rsp_status = rsp_valid ? rs_mem[r_rd_q] : '0;
    rsp_tag    = rsp_valid ? rt_mem[r_rd_q] : '0;
    busy       = !q_empty || (inflight_q != '0) || !r_empty;
  end

`ifdef FADD_STICKY_STATUS_EN
  logic [2:0] sticky_q, sticky_d;

  // A clear and a pop in the same cycle keep the popped status.
  always_comb begin
    sticky_d = sticky_clr ? 3'b000 : sticky_q;
    if (pop) sticky_d = sticky_d | rsp_status;
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= '0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_status = sticky_q;
`endif
endmodule

// File: tb/tb_fadd_issue_queue.sv
// Scoreboard bench for fadd_issue_queue with a behavioural LAT-cycle adder; exercises sticky status when
// FADD_STICKY_STATUS_EN is defined.
module tb_fadd_issue_queue;
  localparam int LAT    = 5;
  localparam int QDEPTH = 4;
  localparam int RDEPTH = 8;
  localparam int TAG_W  = 4;

  logic             clk = 1'b0;
  logic             rst, req_valid, req_ready, req_op;
  logic [15:0]      req_a, req_b;
  logic [TAG_W-1:0] req_tag;
  logic [15:0]      fa_a, fa_b, fa_out;
  logic             fa_add_sub;
  logic [2:0]       fa_status;
  logic             rsp_valid, rsp_ready, busy;
  logic [15:0]      rsp_data;
  logic [2:0]       rsp_status;
  logic [TAG_W-1:0] rsp_tag;
`ifdef FADD_STICKY_STATUS_EN
  logic             sticky_clr;
  logic [2:0]       sticky_status;
  logic [2:0]       obs_sticky;
`endif

  fadd_issue_queue #(.LAT(LAT), .QDEPTH(QDEPTH), .RDEPTH(RDEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_tag(req_tag),
    .fa_a(fa_a), .fa_b(fa_b), .fa_add_sub(fa_add_sub), .fa_out(fa_out), .fa_status(fa_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_status(rsp_status),
    .rsp_tag(rsp_tag), .busy(busy)
`ifdef FADD_STICKY_STATUS_EN
    , .sticky_clr(sticky_clr), .sticky_status(sticky_status)
`endif
  );

  always #5 clk = ~clk;

  // Adder reference: exact half-precision results for the operand pairs used in directed tests,
  // a simple integer stand-in (with a status derived from the operands) for everything else.
  function automatic logic [18:0] fadd_model(input logic [15:0] a, input logic [15:0] b, input logic op);
    if (!op && a == 16'h3C00 && b == 16'h3C00) return {3'b000, 16'h4000};
    if (!op && a == 16'h3C00 && b == 16'h4000) return {3'b000, 16'h4200};
    if (!op && a == 16'h4000 && b == 16'h3C00) return {3'b000, 16'h4200};
    if ( op && a == 16'h4200 && b == 16'h3C00) return {3'b000, 16'h4000};
    if ( op && a == 16'h3C00 && b == 16'h3C00) return {3'b000, 16'h0000};
    return {a[2:0] ^ b[2:0] ^ {op, 2'b00}, op ? a - b : a + b};
  endfunction

  logic [18:0] add_pipe [LAT];
  always @(posedge clk) begin
    add_pipe[0] <= fadd_model(fa_a, fa_b, fa_add_sub);
    for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign fa_status = add_pipe[LAT-1][18:16];
  assign fa_out    = add_pipe[LAT-1][15:0];

  typedef struct packed {
    logic [15:0]      data;
    logic [2:0]       status;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  rsp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  int          n_rsp = 0;
  logic        last_acc, last_pop;
  logic        obs_req_ready, obs_rsp_valid, obs_busy;
  logic [15:0] obs_rsp_data;
  logic [2:0]  obs_rsp_status;
  logic [TAG_W-1:0] obs_rsp_tag;

  // One clock cycle: observe at the falling edge, record handshakes, score responses.
  task automatic cycle();
    rsp_t        exp;
    logic [18:0] m;
    @(negedge clk);
    obs_req_ready  = req_ready;
    obs_rsp_valid  = rsp_valid;
    obs_busy       = busy;
    obs_rsp_data   = rsp_data;
    obs_rsp_status = rsp_status;
    obs_rsp_tag    = rsp_tag;
`ifdef FADD_STICKY_STATUS_EN
    obs_sticky     = sticky_status;
`endif
    last_cyc = cyc;
    last_acc = !rst && req_valid && req_ready;
    last_pop = !rst && rsp_valid && rsp_ready;
    if (last_acc) begin
      m          = fadd_model(req_a, req_b, req_op);
      exp.data   = m[15:0];
      exp.status = m[18:16];
      exp.tag    = req_tag;
      sb.push_back(exp);
    end
    if (last_pop) begin
      n_rsp++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got data=%h status=%b tag=%h, required no response",
                 rsp_data, rsp_status, rsp_tag);
      end else begin
        exp = sb.pop_front();
        if ({rsp_data, rsp_status, rsp_tag} !== {exp.data, exp.status, exp.tag}) begin
          n_fail++;
          $display("FAIL rsp_match: got data=%h status=%b tag=%h, required data=%h status=%b tag=%h",
                   rsp_data, rsp_status, rsp_tag, exp.data, exp.status, exp.tag);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic op,
                      input logic [TAG_W-1:0] tag);
    req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cycle();
      if (last_acc) begin
        req_valid = 1'b0;
        return;
      end
    end
    req_valid = 1'b0;
    n_cmp++; n_fail++;
    $display("FAIL send_timeout: got no acceptance for tag %h, required acceptance within 50 cycles", tag);
  endtask

  task automatic drain(input int bound);
    for (int k = 0; k < bound; k++) begin
      cycle();
      if (sb.size() == 0 && !obs_busy) return;
    end
    n_cmp++; n_fail++;
    $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sb.size());
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = 1'b0; req_tag = '0;
`ifdef FADD_STICKY_STATUS_EN
    sticky_clr = 1'b0;
`endif
    cycle(); cycle();
    n_cmp++;
    if ({obs_req_ready, obs_rsp_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_hold: got req_ready=%b rsp_valid=%b, required 0 0", obs_req_ready, obs_rsp_valid);
    end
    rst = 1'b0;
    cycle();
    n_cmp++;
    if ({obs_req_ready, obs_rsp_valid, obs_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req_ready=%b rsp_valid=%b busy=%b, required 1 0 0",
               obs_req_ready, obs_rsp_valid, obs_busy);
    end
    n_cmp++;
    if ({obs_rsp_data, obs_rsp_status, obs_rsp_tag} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got data=%h status=%b tag=%h, required all zero",
               obs_rsp_data, obs_rsp_status, obs_rsp_tag);
    end
  endtask

  task automatic test_single_op();
    int rsp0;
    rsp_ready = 1'b1;
    rsp0 = n_rsp;
    send(16'h3C00, 16'h4000, 1'b0, 4'd3);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      n_cmp++;
      if (obs_rsp_valid !== (k == 7)) begin
        n_fail++;
        $display("FAIL single_latency: got rsp_valid=%b at t+%0d, required %b", obs_rsp_valid, k, k == 7);
      end
      if (k >= 7) begin
        n_cmp++;
        if (obs_busy !== (k == 7)) begin
          n_fail++;
          $display("FAIL single_busy: got busy=%b at t+%0d, required %b", obs_busy, k, k == 7);
        end
      end
    end
    n_cmp++;
    if (n_rsp - rsp0 != 1) begin
      n_fail++;
      $display("FAIL single_count: got %0d responses, required 1", n_rsp - rsp0);
    end
  endtask

  task automatic test_streaming();
    int t0;
    int pops[$];
    rsp_ready = 1'b1;
    send(16'h3C00, 16'h3C00, 1'b0, 4'd0);
    t0 = last_cyc;
    send(16'h4000, 16'h3C00, 1'b0, 4'd1);
    send(16'h4200, 16'h3C00, 1'b1, 4'd2);
    send(16'h3C00, 16'h3C00, 1'b1, 4'd3);
    n_cmp++;
    if (last_cyc != t0 + 3) begin
      n_fail++;
      $display("FAIL stream_accept: got last accept at t0+%0d, required t0+3", last_cyc - t0);
    end
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_pop) pops.push_back(last_cyc);
    end
    n_cmp++;
    if (pops.size() != 4) begin
      n_fail++;
      $display("FAIL stream_count: got %0d responses, required 4", pops.size());
    end else begin
      n_cmp++;
      if (pops[0] != t0 + 7 || pops[3] != pops[0] + 3) begin
        n_fail++;
        $display("FAIL stream_timing: got first at t0+%0d last at t0+%0d, required t0+7 and t0+10",
                 pops[0] - t0, pops[3] - t0);
      end
    end
  endtask

  // Fills result FIFO and queue, then checks a held 13th request waits for a freed slot.
  task automatic test_backpressure();
    int rsp0, k;
    rsp_ready = 1'b0;
    rsp0 = n_rsp;
    for (int i = 0; i < 12; i++)
      send(16'($urandom_range(0, 16'h3BFF)), 16'($urandom), 1'($urandom), TAG_W'(i));
    req_a = 16'h1234; req_b = 16'h0042; req_op = 1'b1; req_tag = 4'd12; req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cycle();
      n_cmp++;
      if (last_acc || obs_req_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL full_hold: got req_ready=%b accepted=%b, required 0 0", obs_req_ready, last_acc);
      end
    end
    n_cmp++;
    if ({obs_rsp_valid, obs_busy} !== 2'b11 || n_rsp != rsp0) begin
      n_fail++;
      $display("FAIL full_state: got rsp_valid=%b busy=%b pops=%0d, required 1 1 0",
               obs_rsp_valid, obs_busy, n_rsp - rsp0);
    end
    rsp_ready = 1'b1;
    k = 0;
    while (k < 10) begin
      cycle();
      if (last_acc) break;
      k++;
    end
    req_valid = 1'b0;
    n_cmp++;
    if (k != 2) begin
      n_fail++;
      $display("FAIL full_release: got acceptance %0d cycles after first pop, required 2", k);
    end
    drain(100);
    n_cmp++;
    if (n_rsp - rsp0 != 13) begin
      n_fail++;
      $display("FAIL bp_count: got %0d responses, required 13", n_rsp - rsp0);
    end
  endtask

  task automatic test_reset_mid();
    int rsp0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(16'h0100 + 16'(i), 16'h0011, 1'b0, TAG_W'(i + 5));
    cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb.delete();
    rsp_ready = 1'b1;
    rsp0 = n_rsp;
    cycle();
    n_cmp++;
    if ({obs_rsp_valid, obs_busy, obs_req_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL midreset_state: got rsp_valid=%b busy=%b req_ready=%b, required 0 0 1",
               obs_rsp_valid, obs_busy, obs_req_ready);
    end
    for (int c = 0; c < 10; c++) begin
      cycle();
      n_cmp++;
      if (obs_rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_stale: got rsp_valid=%b tag=%h, required 0", obs_rsp_valid, obs_rsp_tag);
      end
    end
    send(16'h4000, 16'h3C00, 1'b0, 4'd9);
    drain(50);
    n_cmp++;
    if (n_rsp - rsp0 != 1) begin
      n_fail++;
      $display("FAIL midreset_new: got %0d responses, required 1", n_rsp - rsp0);
    end
  endtask

`ifdef FADD_STICKY_STATUS_EN
  task automatic test_sticky();
    int k;
    rsp_ready = 1'b1;
    sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0;
    send(16'h0001, 16'h0000, 1'b0, 4'd1);
    send(16'h0004, 16'h0000, 1'b0, 4'd2);
    drain(50);
    n_cmp++;
    if (obs_sticky !== 3'b101) begin
      n_fail++;
      $display("FAIL sticky_or: got %b, required 101", obs_sticky);
    end
    sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0; cycle();
    n_cmp++;
    if (obs_sticky !== 3'b000) begin
      n_fail++;
      $display("FAIL sticky_clr: got %b, required 000", obs_sticky);
    end
    rsp_ready = 1'b0;
    send(16'h0002, 16'h0000, 1'b0, 4'd3);
    k = 0;
    while (k < 20 && !obs_rsp_valid) begin
      cycle();
      k++;
    end
    sticky_clr = 1'b1; rsp_ready = 1'b1;
    cycle();
    sticky_clr = 1'b0;
    cycle();
    n_cmp++;
    if (obs_sticky !== 3'b010 || !last_pop && sb.size() != 0) begin
      n_fail++;
      $display("FAIL sticky_clr_pop: got %b, required 010", obs_sticky);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_op();
    test_streaming();
    test_backpressure();
    test_reset_mid();
`ifdef FADD_STICKY_STATUS_EN
    test_sticky();
`endif
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_empty: got %0d expected responses never seen, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at 500000, required completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fadd_issue_queue.md
Name: fadd_issue_queue

Overview:
- Front-end for the 16-bit half-precision add/sub pipeline.
- Accepts operand requests through a valid/ready handshake and buffers them in an operand queue.
- Issues requests to the adder only when result space is guaranteed, and tracks in-flight ops with a latency-matched tag pipe.
- Captures adder results into a result FIFO and presents them in order with their tags; makes the non-stallable adder usable behind backpressure.

Parameters:
- LAT, 5, cycles from operand issue to result on fa_out/fa_status (must match the adder pipeline).
- QDEPTH, 4, operand queue entries (power of 2).
- RDEPTH, 8, result FIFO entries (power of 2).
- TAG_W, 4, request tag width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset; also drives the adder's rst.
- req_valid  input  1  request present.
- req_ready  output  1  queue can accept.
- req_a  input  16  operand A (half precision).
- req_b  input  16  operand B.
- req_op  input  1  passed unchanged to the adder's add_sub (0 = add, 1 = subtract).
- req_tag  input  TAG_W  user tag returned with the result.
- fa_a  output  16  to adder a.
- fa_b  output  16  to adder b.
- fa_add_sub  output  1  to adder add_sub.
- fa_out  input  16  adder result.
- fa_status  input  3  adder status.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts.
- rsp_data  output  16  result.
- rsp_status  output  3  status captured with the result.
- rsp_tag  output  TAG_W  tag of the result.
- busy  output  1  any entry queued, in flight, or buffered.

Behaviour:
- Reset: queue, tag pipe and result FIFO are emptied; req_ready=0 during reset and 1 the cycle after; rsp_valid=0, rsp_data/rsp_status/rsp_tag=0, busy=0.
- Reset mid-operation discards every queued, in-flight and buffered op; no stale result may appear after reset is released.
- Request handshake:
  - req_ready = !queue_full.
  - Transfer when req_valid && req_ready; the entry is written at that edge.
  - No same-cycle bypass: an entry is issuable from the next cycle.
  - req_ready does not rise in the cycle a full queue pops.
- Issue:
  - issue = !queue_empty && (inflight + rcount < RDEPTH), using the current-cycle counts (conservative).
  - On issue, pop the head and push {1, tag} into stage 0 of the LAT-deep tag pipe.
  - Otherwise push {0, 0}; the pipe shifts every cycle.
  - fa_a/fa_b/fa_add_sub are driven combinationally from the queue head whenever the queue is non-empty, else 0. The adder is free-running; non-issue cycles carry don't-care data.
- Capture:
  - An op issued in cycle t has its result sampled from fa_out/fa_status in cycle t+LAT, when the tag-pipe output bit is 1.
  - The result is written to the result FIFO with its tag at that edge.
  - The credit rule guarantees the FIFO is never full at capture. A capture while full is a design error; assert in simulation.
- inflight: count of valid tag-pipe bits, 0..LAT. Increments on issue, decrements on capture; simultaneous issue and capture leaves it unchanged.
- Response handshake:
  - rsp_valid = !result_empty; rsp_* show the FIFO head.
  - Pop when rsp_valid && rsp_ready.
  - Same-cycle capture and pop are legal; rcount is unchanged.
  - rsp_* hold stable while rsp_valid && !rsp_ready.
- Ordering: strictly in order.
- Minimum latency: request accepted in cycle t appears on rsp_valid in cycle t+LAT+2 (7 with defaults). Throughput is 1 op/cycle when unstalled.
- Pointers wrap modulo depth; full/empty come from counts, not pointer equality.
- busy = !queue_empty || inflight != 0 || !result_empty.

Optional Feature:
- Macro: FADD_STICKY_STATUS_EN.
- Defined: adds input sticky_clr (1) and output sticky_status (3).
  - sticky_status ORs rsp_status of every popped response.
  - sticky_clr=1 clears it to 0; a same-cycle pop's status is still ORed in after the clear.
  - Reset value is 0.
- Undefined: neither port exists and no sticky logic is built.

Test Plan:
- Single op: after reset, push a=0x3C00, b=0x4000, op=0, tag=3 in cycle t with rsp_ready=1 -> rsp_valid in cycle t+7 with rsp_data=0x4200, rsp_tag=3, one cycle only; busy drops the cycle after.
- Streaming: 4 back-to-back requests with tags 0..3 (1.0+1.0, 2.0+1.0, 3.0-1.0, 1.0-1.0 as 0x3C00/0x4000/0x4200 operands) -> 4 consecutive rsp_valid cycles, data 0x4000, 0x4200, 0x4000, 0x0000, tags 0..3 in order.
- Backpressure: rsp_ready=0 and push 12 requests -> exactly 8 issued, rcount reaches 8, queue holds 4, req_ready=0. Then rsp_ready=1 -> all 12 drain in order, none lost or duplicated.
- Queue full: with issue blocked, hold req_valid=1 with a 5th request -> not accepted while req_ready=0; it is accepted the cycle after the first pop frees a slot, with tag intact.
- Reset mid-flight: 3 ops in flight and 2 buffered, rst=1 for one cycle -> rsp_valid=0 and busy=0 the next cycle, no responses over the following 10 cycles, and a new op afterwards completes normally.
- With FADD_STICKY_STATUS_EN: pop responses with status 3'b001 then 3'b100 -> sticky_status=3'b101; pulse sticky_clr -> 0; clear concurrent with a pop of 3'b010 -> 3'b010.
